// File: rtl/dedup_pkg.sv
// Shared definitions for the streaming duplicate remover: FSM states and
// the width helper used to size the unique-entry counter.
package dedup_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

  // Counter must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dedup_match_cam.sv
// Parallel match of one key against every table entry below cnt.
// Purely combinational; unwritten entries are masked off.
module dedup_match_cam
  import dedup_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 9,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] tbl,
  input  logic [CNT_W-1:0]       cnt,
  input  logic [WIDTH-1:0]       key,
  output logic                   hit
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] eq;

  always_comb begin
    valid = '0;
    eq    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CNT_W'(i) < cnt);
      eq[i]    = (tbl[i*WIDTH +: WIDTH] == key);
    end
  end

  assign hit = |(valid & eq);

endmodule

// File: rtl/stream_dedup.sv
// Per-frame streaming duplicate remover: collects first occurrences of each
// value in arrival order, then replays them with a unique count and overflow.
//
// state      | meaning
// ST_COLLECT | accepting frame elements, storing first occurrences
// ST_EMIT    | replaying stored uniques, count/overflow valid
module stream_dedup
  import dedup_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 9,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] unique_count,
  output logic             count_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0]       rd_ptr, rd_nxt;
  logic                   ovf_nxt;
  logic                   wr_en;
  logic                   hit;
  logic                   emit;
  logic [WIDTH-1:0]       tbl [DEPTH];
  logic [DEPTH*WIDTH-1:0] tbl_flat;

  always_comb begin
    tbl_flat = '0;
    for (int i = 0; i < DEPTH; i++) tbl_flat[i*WIDTH +: WIDTH] = tbl[i];
  end

  dedup_match_cam #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_cam (
    .tbl (tbl_flat),
    .cnt (cnt),
    .key (in_data),
    .hit (hit)
  );

  assign emit         = (state == ST_EMIT);
  assign in_ready     = ~emit;
  assign out_valid    = emit;
  assign count_valid  = emit;
  assign unique_count = emit ? cnt : '0;
  assign out_last     = emit && (rd_ptr == cnt - ONE);

  always_comb begin
    out_data = '0;
    if (emit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == rd_ptr) out_data = tbl[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = rd_ptr;
    ovf_nxt   = overflow;
    wr_en     = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (in_valid) begin
          if (!hit) begin
            if (cnt < DEPTH_C) begin
              wr_en   = 1'b1;
              cnt_nxt = cnt + ONE;
            end else begin
              ovf_nxt = 1'b1;
            end
          end
          if (in_last) begin
            state_nxt = ST_EMIT;
            rd_nxt    = '0;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          rd_nxt = rd_ptr + ONE;
          if (out_last) begin
            state_nxt = ST_COLLECT;
            cnt_nxt   = '0;
            rd_nxt    = '0;
            ovf_nxt   = 1'b0;
          end
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_COLLECT;
      cnt      <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rd_ptr   <= rd_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Table contents are qualified by cnt, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == cnt) tbl[i] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_stream_dedup.sv
// Self-checking bench for stream_dedup: directed frames plus random frames
// against a queue-based first-occurrence model, on DEPTH=9 and DEPTH=4 copies.
module tb_stream_dedup;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;

  logic       a_in_ready, a_out_valid, a_out_last, a_count_valid, a_overflow;
  logic [7:0] a_out_data;
  logic [3:0] a_unique_count;
  logic       b_in_ready, b_out_valid, b_out_last, b_count_valid, b_overflow;
  logic [7:0] b_out_data;
  logic [2:0] b_unique_count;

  logic       o_in_ready, o_out_valid, o_out_last, o_count_valid, o_overflow;
  logic [7:0] o_out_data;
  logic [3:0] o_unique_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_dedup #(.WIDTH(8), .DEPTH(9)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last),
    .unique_count(a_unique_count), .count_valid(a_count_valid),
    .overflow(a_overflow)
  );

  stream_dedup #(.WIDTH(8), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last),
    .unique_count(b_unique_count), .count_valid(b_count_valid),
    .overflow(b_overflow)
  );

  assign o_in_ready     = sel ? b_in_ready     : a_in_ready;
  assign o_out_valid    = sel ? b_out_valid    : a_out_valid;
  assign o_out_last     = sel ? b_out_last     : a_out_last;
  assign o_count_valid  = sel ? b_count_valid  : a_count_valid;
  assign o_overflow     = sel ? b_overflow     : a_overflow;
  assign o_out_data     = sel ? b_out_data     : a_out_data;
  assign o_unique_count = sel ? {1'b0, b_unique_count} : a_unique_count;

  // Drive one frame, then drain it, checking every output beat against the model.
  task automatic run_frame(input logic [7:0] d[$], input int depth, input bit stall,
                           input string tag);
    logic [7:0] u[$];
    logic       ovf;
    bit         seen;
    bit         rdy;
    int         k;
    int         cyc;
    u   = {};
    ovf = 1'b0;
    foreach (d[i]) begin
      seen = 1'b0;
      foreach (u[j]) if (u[j] == d[i]) seen = 1'b1;
      if (!seen) begin
        if (u.size() < depth) u.push_back(d[i]);
        else ovf = 1'b1;
      end
    end

    out_ready = 1'b0;
    foreach (d[i]) begin
      n_cmp++;
      if (o_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s in_ready_collect: got %b want 1", tag, o_in_ready);
      end
      in_valid = 1'b1;
      in_data  = d[i];
      in_last  = (i == d.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hxx;

    n_cmp++;
    if (o_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_out_latency: out_valid got %b want 1", tag, o_out_valid);
    end

    k   = 0;
    cyc = 0;
    while (k < u.size() && cyc < 400) begin
      n_cmp++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_count_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s emit_handshake: valid/ready/cv got %b%b%b want 101",
                 tag, o_out_valid, o_in_ready, o_count_valid);
      end
      n_cmp++;
      if (o_out_data !== u[k]) begin
        n_bad++;
        $display("FAIL %s out_data[%0d]: got %0d want %0d", tag, k, o_out_data, u[k]);
      end
      n_cmp++;
      if (o_out_last !== (k == u.size() - 1)) begin
        n_bad++;
        $display("FAIL %s out_last[%0d]: got %b want %b", tag, k, o_out_last,
                 (k == u.size() - 1));
      end
      n_cmp++;
      if (o_unique_count !== 4'(u.size())) begin
        n_bad++;
        $display("FAIL %s unique_count: got %0d want %0d", tag, o_unique_count, u.size());
      end
      n_cmp++;
      if (o_overflow !== ovf) begin
        n_bad++;
        $display("FAIL %s overflow: got %b want %b", tag, o_overflow, ovf);
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (k != u.size()) begin
      n_bad++;
      $display("FAIL %s drain_timeout: drained %0d want %0d", tag, k, u.size());
    end
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_count_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s back_to_collect: valid/ready/cv got %b%b%b want 010",
               tag, o_out_valid, o_in_ready, o_count_valid);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({a_in_ready, a_out_valid, a_out_last, a_count_valid, a_overflow} !== 5'b10000 ||
        a_out_data !== 8'd0 || a_unique_count !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_a: rdy/vld/last/cv/ovf got %b%b%b%b%b data %0d cnt %0d want 10000 0 0",
               a_in_ready, a_out_valid, a_out_last, a_count_valid, a_overflow,
               a_out_data, a_unique_count);
    end
    n_cmp++;
    if ({b_in_ready, b_out_valid, b_out_last, b_count_valid, b_overflow} !== 5'b10000 ||
        b_out_data !== 8'd0 || b_unique_count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_b: rdy/vld/last/cv/ovf got %b%b%b%b%b data %0d cnt %0d want 10000 0 0",
               b_in_ready, b_out_valid, b_out_last, b_count_valid, b_overflow,
               b_out_data, b_unique_count);
    end
  endtask

  task automatic test_mixed();
    sel = 1'b0;
    run_frame('{8'd15, 8'd22, 8'd15, 8'd33, 8'd22, 8'd45, 8'd33, 8'd67, 8'd15}, 9, 1'b0, "mixed");
  endtask

  task automatic test_all_unique();
    sel = 1'b0;
    run_frame('{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}, 9, 1'b0, "all_unique");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_frame('{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5}, 9, 1'b0, "all_same");
    run_frame('{8'd99}, 9, 1'b0, "single");
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    run_frame('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 4, 1'b0, "overflow");
    run_frame('{8'd7}, 4, 1'b0, "after_overflow");
    sel = 1'b0;
  endtask

  task automatic test_stall();
    sel = 1'b0;
    run_frame('{8'd15, 8'd22, 8'd15, 8'd33, 8'd22, 8'd45, 8'd33, 8'd67, 8'd15}, 9, 1'b1, "stall");
  endtask

  task automatic test_mid_reset();
    logic [7:0] part[$];
    sel  = 1'b0;
    part = '{8'd15, 8'd22, 8'd15, 8'd33};
    foreach (part[i]) begin
      in_valid = 1'b1;
      in_data  = part[i];
      in_last  = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_count_valid !== 1'b0 ||
        a_unique_count !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: rdy %b vld %b cv %b cnt %0d want 1 0 0 0",
               a_in_ready, a_out_valid, a_count_valid, a_unique_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_no_partial: out_valid got %b want 0", a_out_valid);
    end
    run_frame('{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}, 9, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    logic [7:0] f[$];
    int         len;
    for (int n = 0; n < 12; n++) begin
      sel = n[0];
      len = $urandom_range(1, 14);
      f   = {};
      for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 9)));
      run_frame(f, sel ? 4 : 9, 1'b1, "random");
    end
    sel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_mixed();
    test_all_unique();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
